// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: strobes one active-low row at a time, debounces a single
// key press/release and publishes the {row_n, col_n} code with press/valid strobes.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [6:0] keyboard,
  output logic       key_valid,
  output logic       key_press
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  // A count of DEBOUNCE_CNT-1 plus the current matching sample makes DEBOUNCE_CNT.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  logic [2:0]      col_meta_q;
  logic [2:0]      col_s;
  state_e          state_q;
  logic [DivW-1:0] div_q;
  logic [CntW-1:0] deb_cnt_q;
  logic [CntW-1:0] rel_cnt_q;
  logic [6:0]      cand_q;
  logic            sample;
  logic            col_valid;
  logic [3:0]      row_next;

  assign sample    = (div_q == DivLast);
  assign col_valid = (col_s == 3'b011) || (col_s == 3'b101) || (col_s == 3'b110);
  assign row_next  = {row_n[0], row_n[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 3'b111;
      col_s      <= 3'b111;
    end else begin
      col_meta_q <= col_n;
      col_s      <= col_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      div_q     <= '0;
      deb_cnt_q <= '0;
      rel_cnt_q <= '0;
      cand_q    <= 7'h7f;
      row_n     <= 4'b0111;
      keyboard  <= 7'h7f;
      key_valid <= 1'b0;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      div_q     <= sample ? '0 : div_q + DivW'(1);
      if (sample) begin
        unique case (state_q)
          StScan: begin
            if (col_valid) begin
              cand_q <= {row_n, col_s};
              if (DEBOUNCE_CNT == 1) begin
                state_q   <= StHeld;
                keyboard  <= {row_n, col_s};
                key_valid <= 1'b1;
                key_press <= 1'b1;
                rel_cnt_q <= '0;
              end else begin
                deb_cnt_q <= CntW'(1);
                state_q   <= StDebounce;
              end
            end else begin
              row_n <= row_next;
            end
          end
          StDebounce: begin
            if (col_s == cand_q[2:0]) begin
              if (deb_cnt_q == CntLast) begin
                state_q   <= StHeld;
                keyboard  <= cand_q;
                key_valid <= 1'b1;
                key_press <= 1'b1;
                rel_cnt_q <= '0;
              end else begin
                deb_cnt_q <= deb_cnt_q + CntW'(1);
              end
            end else begin
              state_q <= StScan;
              row_n   <= row_next;
            end
          end
          StHeld: begin
            // Only an all-open sample counts toward release; anything else restarts it.
            if (col_s == 3'b111) begin
              if (rel_cnt_q == CntLast) begin
                state_q   <= StScan;
                keyboard  <= 7'h7f;
                key_valid <= 1'b0;
                rel_cnt_q <= '0;
                row_n     <= row_next;
              end else begin
                rel_cnt_q <= rel_cnt_q + CntW'(1);
              end
            end else begin
              rel_cnt_q <= '0;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 keypad matrix model.
module tb_keypad_scanner;

  localparam int K1 = 0, K2 = 1, K4 = 3, K5 = 4, K8 = 7, K9 = 8, KSTAR = 9, KHASH = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [6:0] keyboard;
  logic       key_valid;
  logic       key_press;
  logic [11:0] keys = '0;   // index = row*3 + col, row 0 = A, col 0 = E

  int checks = 0;
  int failures = 0;
  int press_cnt = 0;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .keyboard (keyboard),
    .key_valid(key_valid),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3+c] && !row_n[3-r]) col_n[2-c] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (key_press === 1'b1) press_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int decode(input logic [6:0] code);
    case (code)
      7'b0111011: return 1;
      7'b0111101: return 2;
      7'b0111110: return 3;
      7'b1011011: return 4;
      7'b1011101: return 5;
      7'b1011110: return 6;
      7'b1101011: return 7;
      7'b1101101: return 8;
      7'b1101110: return 9;
      7'b1110011: return 10;
      7'b1110101: return 0;
      7'b1110110: return 11;
      default:    return -1;
    endcase
  endfunction

  task automatic wait_row(input logic [3:0] r, input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (row_n === r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_press(input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (key_press === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (key_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({row_n, keyboard, key_valid, key_press} !== {4'b0111, 7'h7f, 2'b00}) begin
      failures++;
      $display("FAIL reset_async: got row=%b kb=%b v=%b p=%b expected row=0111 kb=1111111 v=0 p=0",
               row_n, keyboard, key_valid, key_press);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (row_n !== seq[k/4]) begin
        failures++;
        $display("FAIL scan_seq[%0d]: got %b expected %b", k, row_n, seq[k/4]);
      end
    end
  endtask

  task automatic test_press_5();
    int n, p0;
    bit ok;
    wait_row(4'b1110, 40, n, ok);
    keys[K5] = 1'b1;
    p0 = press_cnt;
    wait_row(4'b1011, 40, n, ok);
    wait_press(40, n, ok);
    checks++;
    if (!ok || n != 12) begin
      failures++;
      $display("FAIL press5_latency: got ok=%0d cycles=%0d expected ok=1 cycles=12", ok, n);
    end
    checks++;
    if (keyboard !== 7'b1011101 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL press5_code: got kb=%b v=%b expected kb=1011101 v=1", keyboard, key_valid);
    end
    checks++;
    if (decode(keyboard) != 5) begin
      failures++;
      $display("FAIL press5_decode: got %0d expected 5", decode(keyboard));
    end
    @(negedge clk);
    checks++;
    if (key_press !== 1'b0) begin
      failures++;
      $display("FAIL press5_pulse_width: got key_press=%b expected 0", key_press);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (row_n !== 4'b1011 || keyboard !== 7'b1011101 || press_cnt - p0 != 1) begin
      failures++;
      $display("FAIL press5_hold: got row=%b kb=%b presses=%0d expected row=1011 kb=1011101 presses=1",
               row_n, keyboard, press_cnt - p0);
    end
    keys[K5] = 1'b0;
    wait_release(40, n, ok);
    checks++;
    if (!ok || n < 11 || n > 14) begin
      failures++;
      $display("FAIL release5_latency: got ok=%0d cycles=%0d expected ok=1 cycles in 11..14", ok, n);
    end
    checks++;
    if (keyboard !== 7'h7f || row_n !== 4'b1101) begin
      failures++;
      $display("FAIL release5_state: got kb=%b row=%b expected kb=1111111 row=1101", keyboard, row_n);
    end
  endtask

  task automatic test_star_hash();
    int n;
    bit ok;
    keys[KSTAR] = 1'b1;
    wait_press(80, n, ok);
    checks++;
    if (!ok || keyboard !== 7'b1110011 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL press_star: got ok=%0d kb=%b v=%b expected ok=1 kb=1110011 v=1",
               ok, keyboard, key_valid);
    end
    keys[KSTAR] = 1'b0;
    wait_release(40, n, ok);
    keys[KHASH] = 1'b1;
    wait_press(80, n, ok);
    checks++;
    if (!ok || keyboard !== 7'b1110110 || decode(keyboard) != 11) begin
      failures++;
      $display("FAIL press_hash: got ok=%0d kb=%b expected ok=1 kb=1110110", ok, keyboard);
    end
    keys[KHASH] = 1'b0;
    wait_release(40, n, ok);
    checks++;
    if (!ok || keyboard !== 7'h7f) begin
      failures++;
      $display("FAIL release_hash: got ok=%0d kb=%b expected ok=1 kb=1111111", ok, keyboard);
    end
  endtask

  task automatic test_bounce();
    int n, p0;
    bit ok;
    wait_row(4'b1011, 40, n, ok);
    wait_row(4'b1101, 40, n, ok);
    p0 = press_cnt;
    keys[K8] = 1'b1;
    repeat (4) @(negedge clk);
    keys[K8] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (row_n !== 4'b1101) begin
      failures++;
      $display("FAIL bounce_row_frozen: got %b expected 1101", row_n);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (row_n !== 4'b1110) begin
      failures++;
      $display("FAIL bounce_abort_row: got %b expected 1110", row_n);
    end
    keys[K8] = 1'b1;
    checks++;
    if (keyboard !== 7'h7f || press_cnt != p0) begin
      failures++;
      $display("FAIL bounce_no_press: got kb=%b presses=%0d expected kb=1111111 presses=0",
               keyboard, press_cnt - p0);
    end
    wait_press(80, n, ok);
    @(negedge clk);
    checks++;
    if (!ok || keyboard !== 7'b1101101 || press_cnt - p0 != 1) begin
      failures++;
      $display("FAIL bounce_stable: got ok=%0d kb=%b presses=%0d expected ok=1 kb=1101101 presses=1",
               ok, keyboard, press_cnt - p0);
    end
    keys[K8] = 1'b0;
    wait_release(40, n, ok);
  endtask

  task automatic test_two_keys();
    int n, p0;
    bit ok, saw_d;
    p0 = press_cnt;
    saw_d = 1'b0;
    keys[K1] = 1'b1;
    keys[K2] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (row_n === 4'b1110) saw_d = 1'b1;
    end
    checks++;
    if (press_cnt != p0 || !saw_d || key_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_row_pair: got presses=%0d scanned_d=%0d v=%b expected presses=0 scanned_d=1 v=0",
               press_cnt - p0, saw_d, key_valid);
    end
    keys = '0;
    keys[K4] = 1'b1;
    wait_press(80, n, ok);
    checks++;
    if (!ok || keyboard !== 7'b1011011) begin
      failures++;
      $display("FAIL press4: got ok=%0d kb=%b expected ok=1 kb=1011011", ok, keyboard);
    end
    @(negedge clk);
    p0 = press_cnt;
    keys[K9] = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (keyboard !== 7'b1011011 || press_cnt != p0 || key_valid !== 1'b1 || row_n !== 4'b1011) begin
      failures++;
      $display("FAIL hold4_press9: got kb=%b presses=%0d v=%b row=%b expected kb=1011011 presses=0 v=1 row=1011",
               keyboard, press_cnt - p0, key_valid, row_n);
    end
    keys = '0;
    wait_release(40, n, ok);
    checks++;
    if (!ok || keyboard !== 7'h7f) begin
      failures++;
      $display("FAIL release4_9: got ok=%0d kb=%b expected ok=1 kb=1111111", ok, keyboard);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    keys[K5] = 1'b1;
    wait_press(80, n, ok);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({row_n, keyboard, key_valid, key_press} !== {4'b0111, 7'h7f, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid: got row=%b kb=%b v=%b p=%b expected row=0111 kb=1111111 v=0 p=0",
               row_n, keyboard, key_valid, key_press);
    end
    keys = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || keyboard !== 7'h7f) begin
      failures++;
      $display("FAIL reset_mid_after: got v=%b kb=%b expected v=0 kb=1111111", key_valid, keyboard);
    end
  endtask

  initial begin
    test_reset();
    test_press_5();
    test_star_hash();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
